// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: A - B, LSB first, one bit per clock, WIDTH-cycle latency.
// Build option: define SERIAL_SUB_SAT_EN to clamp Diff to 0 whenever the result borrows.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow,
  output logic             Busy,
  output logic             Done,
  output logic             dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Handshake: Start is sampled only while idle (Busy=0); the accepting edge raises Busy,
  // and the completion edge drops Busy and pulses Done for one cycle with Diff/Borrow valid.
  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic a_bit, b_bit, d_bit, br_next;

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    part_d   = part_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    a_bit   = opa_q[0];
    b_bit   = opb_q[0];
    d_bit   = a_bit ^ b_bit ^ br_q;
    br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);

    case (state_q)
      IDLE: begin
        if (Start) begin
          opa_d   = A;
          opb_d   = B;
          part_d  = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        part_d = {d_bit, part_q[WIDTH-1:1]};
        opa_d  = opa_q >> 1;
        opb_d  = opb_q >> 1;
        br_d   = br_next;
        cnt_d  = cnt_q + CW'(1);
        // The edge that consumes the top bit finishes the operation.
        if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SERIAL_SUB_SAT_EN
          diff_d = br_next ? '0 : part_d;
`else
          diff_d = part_d;
`endif
          borrow_d = br_next;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      part_q   <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      part_q   <= part_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Diff      = diff_q;
  assign Borrow    = borrow_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign dbg_state = state_q;

endmodule
